// File: rtl/sw_out_arbiter.sv
// rtl/sw_out_arbiter.sv - packet-level round-robin arbiter onto one output port
//
// Purpose:
//   Grants one of NUM_SW_INST sources at a time and holds that grant for a
//   whole packet. Priority rotates to the index after the served source once
//   the packet completes. A beat counter forces EOP on the MAX_PKT_LEN-th beat
//   and flags the truncation with a one-cycle pkt_err pulse.
//
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   src_valid     - per-source beat available
//   src_data      - per-source beat, source i at [i*W_WIDTH +: W_WIDTH]
//   src_eop       - per-source last-beat flag
//   src_pop       - one-hot/zero, beat of granted source consumed this cycle
//   out_ready     - downstream accepts beat
//   out_valid     - out_data holds a valid beat
//   out_data      - beat muxed from the granted source
//   out_eop       - last beat of packet (source EOP or forced truncation)
//   gnt           - registered one-hot grant, zero when idle
//   busy          - packet transfer in progress
//   pkt_err       - one-cycle pulse after a truncating handshake
module sw_out_arbiter #(
   parameter int NUM_SW_INST = 5,
   parameter int W_WIDTH     = 8,
   parameter int MAX_PKT_LEN = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_SW_INST-1:0]         src_valid,
   input  logic [NUM_SW_INST*W_WIDTH-1:0] src_data,
   input  logic [NUM_SW_INST-1:0]         src_eop,
   output logic [NUM_SW_INST-1:0]         src_pop,
   input  logic                           out_ready,
   output logic                           out_valid,
   output logic [W_WIDTH-1:0]             out_data,
   output logic                           out_eop,
   output logic [NUM_SW_INST-1:0]         gnt,
   output logic                           busy,
   output logic                           pkt_err
);

   localparam int CW = $clog2(MAX_PKT_LEN + 1);
   localparam int IW = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PKT_LEN - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SW_INST - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [IW-1:0]          r_gnt_idx, w_gnt_idx_nxt;
   logic [IW-1:0]          r_rr_ptr, w_rr_ptr_nxt;
   logic [CW-1:0]          r_beat_cnt, w_beat_cnt_nxt;
   logic [NUM_SW_INST-1:0] r_gnt, w_gnt_nxt;
   logic                   r_pkt_err, w_pkt_err_nxt;

   logic                   w_xfer;
   logic                   w_last_beat;
   logic                   w_hs;
   logic                   w_any_req;
   logic [IW-1:0]          w_pick_idx;
   logic [IW:0]            w_scan;

   // Round-robin search starting at r_rr_ptr. The loop runs from the farthest
   // offset down so the requester closest to r_rr_ptr is the last one written.
   always_comb begin
      w_pick_idx = r_rr_ptr;
      w_any_req  = 1'b0;
      w_scan     = '0;
      for (int k = NUM_SW_INST - 1; k >= 0; k--) begin
         w_scan = {1'b0, r_rr_ptr} + (IW+1)'(k);
         if (w_scan >= (IW+1)'(NUM_SW_INST))
            w_scan = w_scan - (IW+1)'(NUM_SW_INST);
         if (src_valid[w_scan]) begin
            w_pick_idx = w_scan[IW-1:0];
            w_any_req  = 1'b1;
         end
      end
   end

   assign w_xfer      = (r_state == ST_XFER);
   assign w_last_beat = (r_beat_cnt == LAST_CNT);
   assign out_valid   = w_xfer & src_valid[r_gnt_idx];
   assign out_data    = w_xfer ? src_data[int'(r_gnt_idx)*W_WIDTH +: W_WIDTH] : '0;
   // Counter reaching MAX_PKT_LEN-1 closes the packet even without source EOP.
   assign out_eop     = w_xfer & (src_eop[r_gnt_idx] | w_last_beat);
   assign w_hs        = out_valid & out_ready;
   assign src_pop     = w_hs ? (NUM_SW_INST'(1) << r_gnt_idx) : '0;
   assign gnt         = r_gnt;
   assign busy        = w_xfer;
   assign pkt_err     = r_pkt_err;

   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_idx_nxt  = r_gnt_idx;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_beat_cnt_nxt = r_beat_cnt;
      w_gnt_nxt      = r_gnt;
      w_pkt_err_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_gnt_nxt = '0;
            if (w_any_req) begin
               w_gnt_idx_nxt  = w_pick_idx;
               w_gnt_nxt      = NUM_SW_INST'(1) << w_pick_idx;
               w_beat_cnt_nxt = '0;
               w_state_nxt    = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_hs) begin
               w_beat_cnt_nxt = r_beat_cnt + 1'b1;
               if (out_eop) begin
                  w_rr_ptr_nxt  = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + 1'b1;
                  w_gnt_nxt     = '0;
                  w_state_nxt   = ST_IDLE;
                  // Forced EOP without source EOP means the packet was cut.
                  w_pkt_err_nxt = ~src_eop[r_gnt_idx];
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_gnt_idx  <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
         r_gnt      <= '0;
         r_pkt_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt_idx  <= w_gnt_idx_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_gnt      <= w_gnt_nxt;
         r_pkt_err  <= w_pkt_err_nxt;
      end
   end

endmodule

// File: doc/sw_out_arbiter.md
# sw_out_arbiter

Packet-level round-robin arbiter sharing one downstream output port among NUM_SW_INST switch-instance sources (the FIFO/switch outputs drained by the read controller). It grants one source at a time, holds the grant for a whole packet (until the EOP beat completes), then rotates priority to the next index. A beat counter enforces a maximum packet length; oversized packets are truncated and flagged.

## Interface
- NUM_SW_INST, 5, number of sources (≥2)
- W_WIDTH, 8, data beat width in bits
- MAX_PKT_LEN, 16, maximum beats per packet (≥1); counter width = $clog2(MAX_PKT_LEN+1)
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- src_valid  in  NUM_SW_INST  source i has a beat available
- src_data  in  NUM_SW_INST*W_WIDTH  source i beat at bits [i*W_WIDTH +: W_WIDTH]
- src_eop  in  NUM_SW_INST  source i beat is last of packet
- src_pop  out  NUM_SW_INST  one-hot/zero; beat of source i consumed this cycle
- out_ready  in  1  downstream accepts beat
- out_valid  out  1  beat on out_data valid
- out_data  out  W_WIDTH  muxed beat from granted source
- out_eop  out  1  last beat of packet (source EOP or forced truncation)
- gnt  out  NUM_SW_INST  registered one-hot grant, zero when idle
- busy  out  1  high in XFER state
- pkt_err  out  1  one-cycle pulse when a packet is truncated

## Operation
- States: IDLE, XFER (2-bit encoding, third code unused → IDLE).
- Registers: state, gnt_idx, rr_ptr (next highest-priority index), beat_cnt, gnt, pkt_err.
- IDLE: if any src_valid, select first i with src_valid[i] scanning rr_ptr, rr_ptr+1, …, wrapping N-1→0; load gnt_idx=i, gnt=1<<i, beat_cnt=0, go XFER. No src_valid: stay, gnt=0.
- XFER outputs (combinational from gnt_idx): out_valid=src_valid[gnt_idx]; out_data=src_data slice; out_eop=src_eop[gnt_idx] OR (beat_cnt==MAX_PKT_LEN-1); src_pop[gnt_idx]=out_valid & out_ready, all other bits 0.
- Handshake = out_valid & out_ready. On handshake: beat_cnt+1.
- Handshake with out_eop: rr_ptr=(gnt_idx+1) mod NUM_SW_INST, gnt=0, go IDLE. If src_eop[gnt_idx]==0 on that beat (truncation), pkt_err pulses next cycle; remaining beats of that packet are treated as a new packet by later arbitration.
- Granted source drops src_valid mid-packet: grant held, out_valid=0 (bubble); other sources never interleave.
- out_valid must not depend on out_ready; out_data/out_eop hold while out_valid & !out_ready, provided source holds.
- IDLE: out_valid=0, src_pop=0, out_data=0, out_eop=0.
- rr_ptr only advances on packet completion; unserved requesters keep priority order.

## Timing
- Reset (async assert, sync-released): state=IDLE, gnt=0, gnt_idx=0, rr_ptr=0, beat_cnt=0, pkt_err=0, busy=0; out_valid/out_eop/out_data/src_pop=0.
- Arbitration latency: src_valid seen in IDLE at edge k → gnt/busy high after edge k, first beat can transfer in cycle k+1.
- Single-beat packet: one XFER cycle minimum; after EOP handshake, IDLE for one cycle, so back-to-back packets cost one idle cycle each.
- Throughput within packet: one beat per cycle while src_valid & out_ready.
- pkt_err: high exactly one cycle, the cycle after truncating handshake.
- Reset mid-packet: immediate IDLE, grant dropped, no pop; partial packet not resumed.
- Simultaneous src_eop and beat_cnt==MAX_PKT_LEN-1: normal completion, no pkt_err.

## Test plan
- Reset, then src_valid=5'b00100, 3-beat packet, out_ready=1 → gnt=5'b00100 one cycle after request, 3 beats with src_pop[2] each cycle, out_eop on 3rd, rr_ptr=3, pkt_err=0.
- All five sources valid, 1-beat packets continuously → grant order 0,1,2,3,4,0; each packet followed by one IDLE cycle.
- rr_ptr=4 (after serving source 3), src_valid=5'b10001 → source 4 granted, then source 0 (wrap-around).
- Granted source 1 deasserts src_valid for 2 cycles mid-packet while source 3 valid; out_ready toggled → out_valid low during gap, no src_pop[3], out_data stable under backpressure, source 1 completes packet first.
- MAX_PKT_LEN=16, source 0 sends 20 beats with no EOP → out_eop forced on beat 16, pkt_err pulse next cycle, IDLE, then remaining 4 beats arbitrated as new packet.
- rst_n asserted during beat 2 of a packet → all outputs 0 asynchronously; after release, rr_ptr=0 and arbitration restarts from source 0.
